alu_daa_pipe: RTL and testbench

- Two-stage registered ALU that produces the result fed into the accumulator.
- Consumes the AI/BI operand registers. Stage 1 latches the binary result into the ADD hold register, along with the carry, overflow and half-carry flags.
- Stage 2 applies the decimal adjust and drives the accumulator's DAA data input with a load strobe.
- One operation accepted per cycle. Results are fully pipelined.

---
 rtl/alu_daa_pipe.sv | 138 +++++++++++++
 tb/tb_alu_daa_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_daa_pipe.sv
// Two-stage ALU: stage 1 registers the binary result and flags into the ADD hold register;
// stage 2 applies decimal adjust for the accumulator. Optional feature macro: DECIMAL_MODE_EN.
module alu_daa_pipe #(
    parameter bit SR_FILL_CARRY = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       FLUSH,
    input  logic [2:0] OP,
    input  logic [7:0] AI,
    input  logic [7:0] BI,
    input  logic       CARRY_IN,
    input  logic       DECIMAL,
    input  logic       SUB,
    output logic [7:0] ADD,
    output logic       ADD_VALID,
    output logic       ACR,
    output logic       AVR,
    output logic       HC,
    output logic [7:0] DAA_DATA,
    output logic       DAA_CARRY,
    output logic       ACC_LOAD
);
    // Handshake: START is a valid with no ready (one op accepted every cycle); ADD_VALID and
    // ACC_LOAD are one-cycle valids with no backpressure; FLUSH kills both stages and beats START.
    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_EOR = 3'b011;
    localparam logic [2:0] OP_SR  = 3'b100;

    logic [8:0] sum9;
    logic [4:0] half_sum;
    logic [7:0] s1_res;
    logic       s1_acr, s1_avr, s1_hc;
    logic       accept;

    assign accept = START && !FLUSH;

    always_comb begin
        sum9     = {1'b0, AI} + {1'b0, BI} + {8'd0, CARRY_IN};
        half_sum = {1'b0, AI[3:0]} + {1'b0, BI[3:0]} + {4'd0, CARRY_IN};
        s1_res   = 8'h00;
        s1_acr   = 1'b0;
        s1_avr   = 1'b0;
        s1_hc    = 1'b0;
        case (OP)
            OP_SUM: begin
                s1_res = sum9[7:0];
                s1_acr = sum9[8];
                s1_hc  = half_sum[4];
                s1_avr = (AI[7] == BI[7]) && (sum9[7] != AI[7]);
            end
            OP_AND: s1_res = AI & BI;
            OP_OR:  s1_res = AI | BI;
            OP_EOR: s1_res = AI ^ BI;
            OP_SR: begin
                s1_res = {(SR_FILL_CARRY ? CARRY_IN : 1'b0), AI[7:1]};
                s1_acr = AI[0];
            end
            default: ;  // reserved ops still produce a valid all-zero result
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ADD       <= 8'h00;
            ACR       <= 1'b0;
            AVR       <= 1'b0;
            HC        <= 1'b0;
            ADD_VALID <= 1'b0;
        end else begin
            ADD_VALID <= accept;
            if (accept) begin
                ADD <= s1_res;
                ACR <= s1_acr;
                AVR <= s1_avr;
                HC  <= s1_hc;
            end
        end
    end

    logic [7:0] daa_res;
    logic       daa_c;

`ifdef DECIMAL_MODE_EN
    logic s1_decimal, s1_sub, s1_is_sum;
    logic lo_adj, hi_adj;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_decimal <= 1'b0;
            s1_sub     <= 1'b0;
            s1_is_sum  <= 1'b0;
        end else if (accept) begin
            s1_decimal <= DECIMAL;
            s1_sub     <= SUB;
            s1_is_sum  <= (OP == OP_SUM);
        end
    end

    always_comb begin
        lo_adj  = HC || (ADD[3:0] > 4'd9);
        hi_adj  = ACR || (ADD > 8'h99);
        daa_res = ADD;
        daa_c   = ACR;
        if (s1_decimal && s1_is_sum) begin
            if (!s1_sub) begin
                daa_res = ADD + (lo_adj ? 8'h06 : 8'h00) + (hi_adj ? 8'h60 : 8'h00);
                daa_c   = ACR | hi_adj;
            end else begin
                // subtract correction keys off the borrow-free flags: no carry means borrow
                daa_res = ADD - (HC ? 8'h00 : 8'h06) - (ACR ? 8'h00 : 8'h60);
            end
        end
    end
`else
    logic unused_decimal_inputs;
    assign unused_decimal_inputs = DECIMAL ^ SUB;
    assign daa_res = ADD;
    assign daa_c   = ACR;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DAA_DATA  <= 8'h00;
            DAA_CARRY <= 1'b0;
            ACC_LOAD  <= 1'b0;
        end else begin
            ACC_LOAD <= ADD_VALID && !FLUSH;
            if (ADD_VALID && !FLUSH) begin
                DAA_DATA  <= daa_res;
                DAA_CARRY <= daa_c;
            end
        end
    end
endmodule

// File: tb/tb_alu_daa_pipe.sv
// Bench for alu_daa_pipe: directed test-plan steps then random ops against a reference model.
// Two instances cover both SR_FILL_CARRY settings.
module tb_alu_daa_pipe;
    typedef struct packed {
        logic [7:0] add;
        logic       acr;
        logic       avr;
        logic       hc;
        logic [7:0] daa;
        logic       dc;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, flush = 1'b0, carry_in = 1'b0, decimal = 1'b0, sub = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] ai = 8'h00, bi = 8'h00;

    logic [7:0] add1, daa1, add0, daa0;
    logic       addv1, acr1, avr1, hc1, dc1, load1;
    logic       addv0, acr0, avr0, hc0, dc0, load0;

    int vectors = 0;
    int miscompares = 0;

    // model state: last accepted stage-1 result, held stage-2 outputs, and valids
    res_t       s1_m1, s1_m0;
    logic       m_addv, m_acc;
    logic [7:0] m_daa1, m_daa0;
    logic       m_dc1;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    alu_daa_pipe #(.SR_FILL_CARRY(1'b1)) u1 (
        .CLK(clk), .RST_N(rst_n), .START(start), .FLUSH(flush), .OP(op), .AI(ai), .BI(bi),
        .CARRY_IN(carry_in), .DECIMAL(decimal), .SUB(sub), .ADD(add1), .ADD_VALID(addv1),
        .ACR(acr1), .AVR(avr1), .HC(hc1), .DAA_DATA(daa1), .DAA_CARRY(dc1), .ACC_LOAD(load1)
    );

    alu_daa_pipe #(.SR_FILL_CARRY(1'b0)) u0 (
        .CLK(clk), .RST_N(rst_n), .START(start), .FLUSH(flush), .OP(op), .AI(ai), .BI(bi),
        .CARRY_IN(carry_in), .DECIMAL(decimal), .SUB(sub), .ADD(add0), .ADD_VALID(addv0),
        .ACR(acr0), .AVR(avr0), .HC(hc0), .DAA_DATA(daa0), .DAA_CARRY(dc0), .ACC_LOAD(load0)
    );

    function automatic res_t ref_op(int o, int a, int b, int c, int d, int s, int fill);
        res_t r;
        int   sum, sa, sb, v;
        logic lo, hi;
        r = '0;
        case (o)
            0: begin
                sum   = a + b + c;
                r.add = 8'(sum % 256);
                r.acr = (sum > 255);
                r.hc  = ((a % 16) + (b % 16) + c) > 15;
                sa    = (a > 127) ? a - 256 : a;
                sb    = (b > 127) ? b - 256 : b;
                r.avr = (sa + sb + c > 127) || (sa + sb + c < -128);
            end
            1: r.add = 8'(a & b);
            2: r.add = 8'(a | b);
            3: r.add = 8'(a ^ b);
            4: begin
                r.add = 8'((a / 2) + ((fill != 0 && c != 0) ? 128 : 0));
                r.acr = (a % 2) == 1;
            end
            default: ;
        endcase
        r.daa = r.add;
        r.dc  = r.acr;
`ifdef DECIMAL_MODE_EN
        if (d != 0 && o == 0) begin
            if (s == 0) begin
                lo    = r.hc || (r.add % 16 > 9);
                hi    = r.acr || (r.add > 153);
                v     = int'(r.add) + (lo ? 6 : 0) + (hi ? 96 : 0);
                r.daa = 8'(v % 256);
                r.dc  = r.acr | hi;
            end else begin
                v     = int'(r.add) - (r.hc ? 0 : 6) - (r.acr ? 0 : 96);
                r.daa = 8'((v + 256) % 256);
            end
        end
`else
        if (d + s < 0) r.dc = 1'b0;  // decimal controls have no effect in this build
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s1_m1  = '0;
        s1_m0  = '0;
        m_addv = 1'b0;
        m_acc  = 1'b0;
        m_daa1 = 8'h00;
        m_daa0 = 8'h00;
        m_dc1  = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_all();
        logic [7:0] e;
        chk("add_valid", 16'(addv1), 16'(m_addv));
        chk("acc_load", 16'(load1), 16'(m_acc));
        chk("add", 16'(add1), 16'(s1_m1.add));
        chk("acr", 16'(acr1), 16'(s1_m1.acr));
        chk("avr", 16'(avr1), 16'(s1_m1.avr));
        chk("hc", 16'(hc1), 16'(s1_m1.hc));
        if (m_acc && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("daa_data_sb", 16'(daa1), 16'(e));
        end else begin
            chk("daa_data", 16'(daa1), 16'(m_daa1));
        end
        chk("daa_carry", 16'(dc1), 16'(m_dc1));
        chk("sr0_add", 16'(add0), 16'(s1_m0.add));
        chk("sr0_daa", 16'(daa0), 16'(m_daa0));
        chk("sr0_load", 16'(load0), 16'(m_acc));
    endtask

    // drive one cycle from a negedge, update the model at the edge, check at the next negedge
    task automatic drive(input logic st, input logic fl, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic c, input logic d, input logic s);
        start = st; flush = fl; op = o; ai = a; bi = b; carry_in = c; decimal = d; sub = s;
        @(posedge clk);
        if (fl) begin
            m_addv = 1'b0;
            m_acc  = 1'b0;
        end else begin
            m_acc = m_addv;
            if (m_addv) begin
                m_daa1 = s1_m1.daa;
                m_dc1  = s1_m1.dc;
                m_daa0 = s1_m0.daa;
                exp_q.push_back(s1_m1.daa);
            end
            m_addv = st;
            if (st) begin
                s1_m1 = ref_op(int'(o), int'(a), int'(b), int'(c), int'(d), int'(s), 1);
                s1_m0 = ref_op(int'(o), int'(a), int'(b), int'(c), int'(d), int'(s), 0);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // SUM 0x50+0x50 binary
        drive(1'b1, 1'b0, 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
        chk("tp_add_a0", 16'(add1), 16'h00A0);
        chk("tp_avr", 16'(avr1), 16'h0001);
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("tp_daa_a0", 16'(daa1), 16'h00A0);
        chk("tp_load", 16'(load1), 16'h0001);

        // decimal add / subtract cases
        drive(1'b1, 1'b0, 3'd0, 8'h19, 8'h28, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'h42, 8'hEC, 1'b1, 1'b1, 1'b1);
`ifdef DECIMAL_MODE_EN
        chk("tp_dsa_add", 16'(add1), 16'h002F);
`endif
        idle(1);
`ifdef DECIMAL_MODE_EN
        chk("tp_dsa_daa", 16'(daa1), 16'h0029);
        chk("tp_dsa_c", 16'(dc1), 16'h0001);
`endif
        idle(1);

        // SR both fill settings
        drive(1'b1, 1'b0, 3'd4, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("tp_sr_fill1", 16'(add1), 16'h00C0);
        chk("tp_sr_fill0", 16'(add0), 16'h0040);
        chk("tp_sr_acr", 16'(acr0), 16'h0001);
        idle(2);

        // back-to-back logic ops
        drive(1'b1, 1'b0, 3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd2, 8'h0F, 8'h30, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd3, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle(3);

        // reserved op, then flush right after START, then flush colliding with START
        drive(1'b1, 1'b0, 3'd6, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'd1, 8'hAA, 8'h55, 1'b0, 1'b0, 1'b0);
        idle(3);

        // reset mid-pipeline
        drive(1'b1, 1'b0, 3'd0, 8'h77, 8'h11, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                  3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
